// File: rtl/ac_run_level_scan.sv
`timescale 1ns/1ps
// ac_run_level_scan: walks one quantised 8x8 block in ProRes progressive scan
// order and streams a DC beat, one run/level beat per non-zero AC coefficient,
// and an end-of-block beat carrying the trailing-zero count.
module ac_run_level_scan #(
    parameter int COEFF_W = 32,
    parameter int RUN_W   = 6,
    parameter int CNT_W   = 16
) (
    input  logic                 CLOCK,
    input  logic                 RESET,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    input  logic [COEFF_W-1:0]   IN_BLOCK [8][8],
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic [1:0]           OUT_TYPE,
    output logic [RUN_W-1:0]     OUT_RUN,
    output logic [COEFF_W-1:0]   OUT_LEVEL,
    output logic                 OUT_SIGN,
    output logic [CNT_W-1:0]     BLOCK_COUNT
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SCAN     = 2'd1,
        ST_EOB_WAIT = 2'd2
    } state_t;

    localparam logic [1:0]         TYPE_DC   = 2'd0;
    localparam logic [1:0]         TYPE_AC   = 2'd1;
    localparam logic [1:0]         TYPE_EOB  = 2'd2;
    localparam logic [COEFF_W-1:0] ZERO_C    = {COEFF_W{1'b0}};
    localparam logic [COEFF_W-1:0] ONE_C     = {{(COEFF_W-1){1'b0}}, 1'b1};
    localparam logic [COEFF_W-1:0] MOST_NEG  = {1'b1, {(COEFF_W-1){1'b0}}};
    localparam logic [COEFF_W-1:0] MAX_POS   = {1'b0, {(COEFF_W-1){1'b1}}};
    localparam logic [RUN_W-1:0]   RUN_ZERO  = {RUN_W{1'b0}};
    localparam logic [RUN_W-1:0]   RUN_ONE   = {{(RUN_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    // Scan position -> raster index (r*8+c).
    localparam logic [5:0] SCAN_TAB [64] = '{
        6'd0,  6'd1,  6'd8,  6'd9,  6'd2,  6'd3,  6'd10, 6'd11,
        6'd16, 6'd17, 6'd24, 6'd25, 6'd18, 6'd19, 6'd26, 6'd27,
        6'd4,  6'd5,  6'd12, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14,
        6'd21, 6'd28, 6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd31,
        6'd32, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34, 6'd35, 6'd42,
        6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36, 6'd37, 6'd44,
        6'd51, 6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    // Unsigned magnitude; the most negative value has no positive twin and
    // saturates to the largest positive value.
    function automatic logic [COEFF_W-1:0] abs_sat(input logic [COEFF_W-1:0] v);
        if (v == MOST_NEG) begin
            return MAX_POS;
        end else if (v[COEFF_W-1]) begin
            return (~v) + ONE_C;
        end else begin
            return v;
        end
    endfunction

    state_t               r_state;
    logic [COEFF_W-1:0]   r_block [64];
    logic [6:0]           r_pos;      // bit 6 set once all 63 AC positions are evaluated
    logic [RUN_W-1:0]     r_run;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic [1:0]           r_out_type;
    logic [RUN_W-1:0]     r_out_run;
    logic [COEFF_W-1:0]   r_out_level;
    logic                 r_out_sign;
    logic [CNT_W-1:0]     r_count;

    state_t               w_state_nx;
    logic [6:0]           w_pos_nx;
    logic [RUN_W-1:0]     w_run_nx;
    logic                 w_valid_nx;
    logic [1:0]           w_type_nx;
    logic [RUN_W-1:0]     w_orun_nx;
    logic [COEFF_W-1:0]   w_level_nx;
    logic                 w_sign_nx;
    logic [CNT_W-1:0]     w_count_nx;
    logic                 w_capture;
    logic                 w_free;
    logic [COEFF_W-1:0]   w_coeff;

    assign w_free  = (!r_out_valid) || OUT_READY;
    assign w_coeff = r_block[SCAN_TAB[r_pos[5:0]]];

    // Next-state and next-output decode for the scan FSM.
    always_comb begin
        w_state_nx = r_state;
        w_pos_nx   = r_pos;
        w_run_nx   = r_run;
        w_valid_nx = r_out_valid;
        w_type_nx  = r_out_type;
        w_orun_nx  = r_out_run;
        w_level_nx = r_out_level;
        w_sign_nx  = r_out_sign;
        w_count_nx = r_count;
        w_capture  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (IN_VALID && r_in_ready) begin
                    w_capture  = 1'b1;
                    w_type_nx  = TYPE_DC;
                    w_orun_nx  = RUN_ZERO;
                    w_level_nx = IN_BLOCK[0][0];
                    w_sign_nx  = 1'b0;
                    w_valid_nx = 1'b1;
                    w_pos_nx   = 7'd1;
                    w_run_nx   = RUN_ZERO;
                    w_state_nx = ST_SCAN;
                end else begin
                    w_valid_nx = 1'b0;
                end
            end
            ST_SCAN: begin
                if (!w_free) begin
                    w_state_nx = ST_SCAN;
                end else if (r_pos[6]) begin
                    w_type_nx  = TYPE_EOB;
                    w_orun_nx  = r_run;
                    w_level_nx = ZERO_C;
                    w_sign_nx  = 1'b0;
                    w_valid_nx = 1'b1;
                    w_state_nx = ST_EOB_WAIT;
                end else if (w_coeff == ZERO_C) begin
                    w_run_nx   = r_run + RUN_ONE;
                    w_pos_nx   = r_pos + 7'd1;
                    w_valid_nx = 1'b0;
                end else begin
                    w_type_nx  = TYPE_AC;
                    w_orun_nx  = r_run;
                    w_level_nx = abs_sat(w_coeff);
                    w_sign_nx  = w_coeff[COEFF_W-1];
                    w_valid_nx = 1'b1;
                    w_run_nx   = RUN_ZERO;
                    w_pos_nx   = r_pos + 7'd1;
                end
            end
            ST_EOB_WAIT: begin
                if (OUT_READY) begin
                    w_count_nx = r_count + CNT_ONE;
                    w_valid_nx = 1'b0;
                    w_state_nx = ST_IDLE;
                end else begin
                    w_state_nx = ST_EOB_WAIT;
                end
            end
            default: begin
                w_valid_nx = 1'b0;
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    // State, scan counters and registered outputs.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_state     <= ST_IDLE;
            r_pos       <= 7'd0;
            r_run       <= RUN_ZERO;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_type  <= TYPE_DC;
            r_out_run   <= RUN_ZERO;
            r_out_level <= ZERO_C;
            r_out_sign  <= 1'b0;
            r_count     <= {CNT_W{1'b0}};
        end else begin
            r_state     <= w_state_nx;
            r_pos       <= w_pos_nx;
            r_run       <= w_run_nx;
            r_in_ready  <= (w_state_nx == ST_IDLE);
            r_out_valid <= w_valid_nx;
            r_out_type  <= w_type_nx;
            r_out_run   <= w_orun_nx;
            r_out_level <= w_level_nx;
            r_out_sign  <= w_sign_nx;
            r_count     <= w_count_nx;
        end
    end

    // Block capture; contents are only meaningful after a handshake.
    always_ff @(posedge CLOCK) begin
        if (w_capture) begin
            for (int r = 0; r < 8; r++) begin
                for (int c = 0; c < 8; c++) begin
                    r_block[r*8+c] <= IN_BLOCK[r][c];
                end
            end
        end else begin
            r_block <= r_block;
        end
    end

    assign IN_READY    = r_in_ready;
    assign OUT_VALID   = r_out_valid;
    assign OUT_TYPE    = r_out_type;
    assign OUT_RUN     = r_out_run;
    assign OUT_LEVEL   = r_out_level;
    assign OUT_SIGN    = r_out_sign;
    assign BLOCK_COUNT = r_count;

endmodule

// File: tb/tb_ac_run_level_scan.sv
`timescale 1ns/1ps
// Bench for ac_run_level_scan: directed and random blocks checked against a
// beat-list model built from the scan table and run/level rules.
module tb_ac_run_level_scan;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic        IN_VALID;
    logic        IN_READY;
    logic [31:0] blk [8][8];
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [1:0]  OUT_TYPE;
    logic [5:0]  OUT_RUN;
    logic [31:0] OUT_LEVEL;
    logic        OUT_SIGN;
    logic [15:0] BLOCK_COUNT;

    ac_run_level_scan #(.COEFF_W(32), .RUN_W(6), .CNT_W(16)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .IN_BLOCK(blk), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .OUT_TYPE(OUT_TYPE), .OUT_RUN(OUT_RUN), .OUT_LEVEL(OUT_LEVEL),
        .OUT_SIGN(OUT_SIGN), .BLOCK_COUNT(BLOCK_COUNT)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct {
        logic [1:0]  t;
        logic [5:0]  run;
        logic [31:0] lvl;
        logic        sgn;
    } beat_t;

    int scan_tab [64] = '{0,1,8,9,2,3,10,11,16,17,24,25,18,19,26,27,4,5,12,20,13,6,7,14,
                          21,28,29,22,15,23,30,31,32,33,40,48,41,34,35,42,49,56,57,50,43,36,37,44,
                          51,58,59,52,45,38,39,46,53,60,61,54,47,55,62,63};

    beat_t exp_q [$];
    int    n_checks  = 0;
    int    n_err     = 0;
    int    exp_count = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic clear_block();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                blk[r][c] = 32'd0;
    endtask

    // Expected beat list: DC, one beat per non-zero AC in scan order, EOB.
    task automatic build_expected();
        beat_t b;
        int    run;
        logic signed [31:0] v;
        exp_q.delete();
        b.t = 2'd0; b.run = 6'd0; b.lvl = blk[0][0]; b.sgn = 1'b0;
        exp_q.push_back(b);
        run = 0;
        for (int i = 1; i < 64; i++) begin
            v = blk[scan_tab[i] / 8][scan_tab[i] % 8];
            if (v == 0) begin
                run++;
            end else begin
                b.t   = 2'd1;
                b.run = 6'(run);
                b.sgn = (v < 0);
                if (v == 32'sh8000_0000) b.lvl = 32'h7FFF_FFFF;
                else if (v < 0)          b.lvl = 32'(-v);
                else                     b.lvl = 32'(v);
                exp_q.push_back(b);
                run = 0;
            end
        end
        b.t = 2'd2; b.run = 6'(run); b.lvl = 32'd0; b.sgn = 1'b0;
        exp_q.push_back(b);
    endtask

    // Feed blk, drain beats under the given ready pattern and compare.
    // mode 0: ready high; 1: toggle with a 10-cycle stall; 2: random.
    // abort_k != 0 returns at that cycle with the block still in flight.
    task automatic run_block(input int mode, input int abort_k);
        int    k;
        logic  rdy;
        logic  stalled;
        beat_t prev;
        beat_t e;
        build_expected();
        @(negedge CLOCK);
        check("in_ready_idle", 64'(IN_READY), 64'd1);
        IN_VALID = 1'b1;
        k = 0;
        stalled = 1'b0;
        prev = '{2'd0, 6'd0, 32'd0, 1'b0};
        forever begin
            @(negedge CLOCK);
            k++;
            IN_VALID = 1'b0;
            if (abort_k != 0 && k == abort_k) return;
            if (stalled) begin
                check("stall_valid", 64'(OUT_VALID), 64'd1);
                check("stall_beat", {OUT_TYPE, OUT_RUN, OUT_LEVEL, OUT_SIGN},
                      {prev.t, prev.run, prev.lvl, prev.sgn});
            end
            if (IN_READY) begin
                if (mode == 0) check("ready_latency", 64'(k), 64'd66);
                break;
            end
            if (k > 2000) begin
                check("timeout", 64'(k), 64'd0);
                break;
            end
            if (mode == 0)      rdy = 1'b1;
            else if (mode == 1) rdy = (k >= 40 && k < 50) ? 1'b0 : k[0];
            else                rdy = 1'($urandom_range(0, 1));
            OUT_READY = rdy;
            if (OUT_VALID && rdy) begin
                if (exp_q.size() == 0) begin
                    check("beat_extra", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_type",  64'(OUT_TYPE),  64'(e.t));
                    check("beat_run",   64'(OUT_RUN),   64'(e.run));
                    check("beat_level", 64'(OUT_LEVEL), 64'(e.lvl));
                    check("beat_sign",  64'(OUT_SIGN),  64'(e.sgn));
                end
            end
            stalled = OUT_VALID && !rdy;
            prev = '{OUT_TYPE, OUT_RUN, OUT_LEVEL, OUT_SIGN};
        end
        exp_count++;
        check("beats_missing", 64'(exp_q.size()), 64'd0);
        check("block_count", 64'(BLOCK_COUNT), 64'(exp_count));
        check("out_valid_idle", 64'(OUT_VALID), 64'd0);
    endtask

    initial begin
        RESET = 1'b1;
        IN_VALID = 1'b0;
        OUT_READY = 1'b0;
        clear_block();
        repeat (2) @(negedge CLOCK);
        RESET = 1'b0;
        check("rst_out_valid", 64'(OUT_VALID), 64'd0);
        check("rst_in_ready", 64'(IN_READY), 64'd1);
        check("rst_type", 64'(OUT_TYPE), 64'd0);
        check("rst_run", 64'(OUT_RUN), 64'd0);
        check("rst_level", 64'(OUT_LEVEL), 64'd0);
        check("rst_sign", 64'(OUT_SIGN), 64'd0);
        check("rst_count", 64'(BLOCK_COUNT), 64'd0);

        // DC only
        clear_block(); blk[0][0] = 32'd100;
        run_block(0, 0);
        // raster 1 = -5
        clear_block(); blk[0][0] = 32'd7; blk[0][1] = -32'sd5;
        run_block(0, 0);
        // raster 63 = 7
        clear_block(); blk[7][7] = 32'd7;
        run_block(0, 0);
        // raster 8 = most negative, negative DC
        clear_block(); blk[0][0] = -32'sd50; blk[1][0] = 32'h8000_0000;
        run_block(0, 0);
        // all AC = 1 under toggling / stalled ready
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                blk[r][c] = 32'd1;
        blk[0][0] = 32'd3;
        run_block(1, 0);

        // reset in the middle of a scan
        clear_block(); blk[0][0] = 32'd11; blk[5][3] = 32'd4;
        run_block(0, 20);
        RESET = 1'b1;
        OUT_READY = 1'b1;
        @(negedge CLOCK);
        RESET = 1'b0;
        check("midrst_out_valid", 64'(OUT_VALID), 64'd0);
        check("midrst_in_ready", 64'(IN_READY), 64'd1);
        check("midrst_count", 64'(BLOCK_COUNT), 64'd0);
        exp_q.delete();
        exp_count = 0;
        clear_block(); blk[0][0] = -32'sd9;
        run_block(0, 0);

        // random sparse blocks under random and toggling back-pressure
        for (int n = 0; n < 6; n++) begin
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++)
                    blk[r][c] = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'd0;
            if (n == 0) blk[2][2] = 32'h8000_0000;
            run_block((n == 5) ? 1 : ((n == 4) ? 0 : 2), 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/ac_run_level_scan.md
Name: ac_run_level_scan

Overview:
- Sits between pre_quant_qt_qscale and the entropy coders.
- Takes one quantised 8x8 block and walks it in ProRes progressive scan order.
- Emits one DC beat, then one run/level beat per non-zero AC coefficient, then an end-of-block (EOB) beat carrying the trailing-zero count.
- Output feeds entropy_encode_dc_coefficients (DC beats) and the AC run/level coders (AC and EOB beats) through a valid/ready stream.

Parameters:
- COEFF_W, 32, coefficient width; signed two's complement.
- RUN_W, 6, run field width; covers 0..63.
- CNT_W, 16, width of the completed-block counter.

Ports:
- CLOCK  input  1  single clock; all state changes on its rising edge.
- RESET  input  1  synchronous, active-high reset.
- IN_VALID  input  1  IN_BLOCK holds a valid block.
- IN_READY  output  1  block can be accepted; high only in IDLE.
- IN_BLOCK  input  [COEFF_W-1:0][8][8]  quantised block, [row][col], raster index r*8+c.
- OUT_VALID  output  1  output beat valid.
- OUT_READY  input  1  downstream accepts the beat.
- OUT_TYPE  output  2  0=DC, 1=AC pair, 2=EOB; 3 is never driven.
- OUT_RUN  output  RUN_W  zeros preceding the AC coefficient; trailing zeros on EOB; 0 on DC.
- OUT_LEVEL  output  COEFF_W  DC: raw signed value. AC: unsigned magnitude. EOB: 0.
- OUT_SIGN  output  1  AC: 1 if the coefficient is negative. 0 on DC and EOB.
- BLOCK_COUNT  output  CNT_W  count of blocks whose EOB was accepted; wraps modulo 2^CNT_W.

Behaviour:
- Reset (synchronous, RESET=1 at a rising edge):
  - state=IDLE, IN_READY=1, OUT_VALID=0.
  - OUT_TYPE/OUT_RUN/OUT_LEVEL/OUT_SIGN=0, BLOCK_COUNT=0, pos=0, run=0.
  - A reset mid-block discards the block and any pending beat. No partial EOB is emitted.
- Scan table SCAN[0..63], raster indices:
  0,1,8,9,2,3,10,11,16,17,24,25,18,19,26,27,4,5,12,20,13,6,7,14,21,28,29,22,15,23,30,31,32,33,40,48,41,34,35,42,49,56,57,50,43,36,37,44,51,58,59,52,45,38,39,46,53,60,61,54,47,55,62,63.
- "Free" means OUT_VALID=0, or OUT_VALID=1 and OUT_READY=1 in the same cycle.
- All outputs are registered. OUT_* stay stable while OUT_VALID=1 and OUT_READY=0.
- FSM states: IDLE, SCAN, EOB_WAIT.
- IDLE:
  - On IN_VALID&IN_READY, the block is captured into an internal register.
  - In the same edge the output register is loaded with the DC beat (type 0, level = coefficient at raster 0).
  - Also: OUT_VALID<=1, pos<=1, run<=0, state<=SCAN.
  - DC appears the cycle after the handshake (latency 1).
- SCAN: each cycle the output is free, evaluate c = block[SCAN[pos]]:
  - c==0: run<=run+1, pos<=pos+1. No beat is loaded, so OUT_VALID drops if the previous beat was just consumed. Zeros are skipped at one per cycle.
  - c!=0: load an AC beat with run, |c|, and sign=c[COEFF_W-1]. Then run<=0, pos<=pos+1.
  - Magnitude of the most negative value (-2^(COEFF_W-1)) saturates to 2^(COEFF_W-1)-1, with sign=1.
  - After pos 63 is evaluated (that edge also loads pos 63's AC beat if c!=0), the next free cycle loads the EOB beat (type 2, OUT_RUN=run) and sets state<=EOB_WAIT.
  - When the output is not free, pos and run hold.
- EOB_WAIT:
  - When the EOB beat is accepted: BLOCK_COUNT<=BLOCK_COUNT+1, OUT_VALID<=0, state<=IDLE.
  - IN_READY rises the cycle after EOB acceptance; there is no overlap of blocks.
- Beat counts and bounds:
  - Every block produces exactly 1 DC beat, N AC beats (N = non-zero AC count, 0..63) and 1 EOB beat.
  - Sum of the AC-beat runs + EOB run + N = 63.
- With OUT_READY held at 1, a block occupies 1 + 63 + 1 cycles from capture to EOB acceptance (66 cycles to the next IN_READY), independent of content.
- IN_BLOCK is ignored outside the IDLE handshake cycle.

Test Plan:
- All-zero AC, DC=100, OUT_READY=1 -> beats DC(level 100), EOB(run 63). BLOCK_COUNT=1. IN_READY returns 66 cycles after capture.
- Raster1=-5, rest AC zero -> DC, AC(run 0, level 5, sign 1), EOB(run 62).
- Raster63=7 only -> DC, AC(run 62, level 7, sign 0), EOB(run 0).
- Raster8=-2^31 only -> AC(run 1, level 0x7FFFFFFF, sign 1), EOB(run 61).
- All 63 AC non-zero (value 1); OUT_READY toggled 1/0 every cycle, then held 0 for 10 cycles on an AC beat:
  - 63 AC beats, all run 0; EOB run 0.
  - Beats stable while stalled; no beat lost or duplicated.
- RESET pulsed for 1 cycle mid-SCAN (pos≈20), then a new all-zero block -> next cycle OUT_VALID=0, IN_READY=1, BLOCK_COUNT=0. The new block yields exactly DC and EOB(run 63).
